// File: rtl/rob_commit.sv
// Reorder buffer with dual-slot allocation, three completion ports and in-order
// dual retirement (at most one memory op per edge), plus mispredict flush.
module rob_commit #(
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FREEZE,
    input  logic              alloc_valid1,
    input  logic              alloc_valid2,
    input  logic [PTR_W-1:0]  alloc_dest1,
    input  logic [PTR_W-1:0]  alloc_dest2,
    input  logic              alloc_wb1,
    input  logic              alloc_wb2,
    input  logic [1:0]        alloc_kind1,
    input  logic [1:0]        alloc_kind2,
    output logic              alloc_ready,
    output logic [PTR_W-1:0]  ROB_tail_pointer1,
    output logic [PTR_W-1:0]  ROB_tail_pointer2,
    input  logic              cmp1_valid,
    input  logic [PTR_W-1:0]  cmp1_tag,
    input  logic [DATA_W-1:0] cmp1_data,
    input  logic              cmp2_valid,
    input  logic [PTR_W-1:0]  cmp2_tag,
    input  logic [DATA_W-1:0] cmp2_data,
    input  logic              cmpLS_valid,
    input  logic [PTR_W-1:0]  cmpLS_tag,
    input  logic [DATA_W-1:0] cmpLS_data,
    input  logic              FLUSH,
    input  logic [PTR_W-1:0]  flush_tag,
    output logic [DATA_W-1:0] fwd_data_1_COM,
    output logic [DATA_W-1:0] fwd_data_2_COM,
    output logic [PTR_W-1:0]  fwd_reg_1_COM,
    output logic [PTR_W-1:0]  fwd_reg_2_COM,
    output logic              fwd_data_1_COM_flag,
    output logic              fwd_data_2_COM_flag,
    output logic [DATA_W-1:0] LS_fwd_data_COM,
    output logic [PTR_W-1:0]  LS_fwd_reg_COM,
    output logic              LS_fwd_data_COM_flag,
    output logic              store_commit,
    output logic [PTR_W-1:0]  store_commit_tag,
    output logic [PTR_W:0]    rob_count
);

    typedef enum logic [1:0] {
        K_ALU    = 2'b00,
        K_LOAD   = 2'b01,
        K_STORE  = 2'b10,
        K_BRANCH = 2'b11
    } kind_e;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    logic              valid_q [DEPTH];
    logic              done_q  [DEPTH];
    logic              wb_q    [DEPTH];
    kind_e             kind_q  [DEPTH];
    logic [PTR_W-1:0]  dest_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] head_p1, tail_p1, flush_off;
    logic             ret_a, ret_b, alloc1, alloc2, flush_ret;
    logic [1:0]       ret_n, alloc_n;

    function automatic logic is_mem(input kind_e k);
        return (k == K_LOAD) || (k == K_STORE);
    endfunction

    assign head_p1           = head_q + PTR_ONE;
    assign tail_p1           = tail_q + PTR_ONE;
    assign ROB_tail_pointer1 = tail_q;
    assign ROB_tail_pointer2 = tail_p1;
    assign rob_count         = count_q;
    assign alloc_ready       = ((CNT_MAX - count_q) >= CNT_TWO) && !FLUSH;

    always_comb begin
        ret_a     = !FREEZE && valid_q[head_q] && done_q[head_q];
        ret_b     = ret_a && valid_q[head_p1] && done_q[head_p1]
                    && !(is_mem(kind_q[head_q]) && is_mem(kind_q[head_p1]));
        ret_n     = {1'b0, ret_a} + {1'b0, ret_b};
        head_d    = head_q + PTR_W'(ret_n);
        alloc1    = alloc_ready && !FREEZE && alloc_valid1;
        alloc2    = alloc1 && alloc_valid2;
        alloc_n   = {1'b0, alloc1} + {1'b0, alloc2};
        flush_ret = (ret_a && (head_q == flush_tag)) || (ret_b && (head_p1 == flush_tag));
        flush_off = flush_tag - head_q;
        if (FLUSH) begin
            // Survivors are head_d..flush_tag; none remain if the branch itself retired.
            tail_d  = flush_tag + PTR_ONE;
            count_d = flush_ret ? '0 : ({1'b0, flush_tag - head_d} + CNT_ONE);
        end else begin
            tail_d  = tail_q + PTR_W'(alloc_n);
            count_d = count_q + (PTR_W+1)'(alloc_n) - (PTR_W+1)'(ret_n);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head_q               <= '0;
            tail_q               <= '0;
            count_q              <= '0;
            fwd_data_1_COM       <= '0;
            fwd_data_2_COM       <= '0;
            fwd_reg_1_COM        <= '0;
            fwd_reg_2_COM        <= '0;
            fwd_data_1_COM_flag  <= 1'b0;
            fwd_data_2_COM_flag  <= 1'b0;
            LS_fwd_data_COM      <= '0;
            LS_fwd_reg_COM       <= '0;
            LS_fwd_data_COM_flag <= 1'b0;
            store_commit         <= 1'b0;
            store_commit_tag     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;

            fwd_data_1_COM_flag  <= 1'b0;
            fwd_data_2_COM_flag  <= 1'b0;
            LS_fwd_data_COM_flag <= 1'b0;
            store_commit         <= 1'b0;

            if (ret_a) begin
                if (kind_q[head_q] == K_LOAD) begin
                    if (wb_q[head_q] && (dest_q[head_q] != '0)) begin
                        LS_fwd_data_COM      <= data_q[head_q];
                        LS_fwd_reg_COM       <= dest_q[head_q];
                        LS_fwd_data_COM_flag <= 1'b1;
                    end
                end else begin
                    if (wb_q[head_q] && (dest_q[head_q] != '0)) begin
                        fwd_data_1_COM      <= data_q[head_q];
                        fwd_reg_1_COM       <= dest_q[head_q];
                        fwd_data_1_COM_flag <= 1'b1;
                    end
                    if (kind_q[head_q] == K_STORE) begin
                        store_commit     <= 1'b1;
                        store_commit_tag <= head_q;
                    end
                end
            end

            // Slot B never shares the memory path with slot A, so the LS/store outputs are free.
            if (ret_b) begin
                if (kind_q[head_p1] == K_LOAD) begin
                    if (wb_q[head_p1] && (dest_q[head_p1] != '0)) begin
                        LS_fwd_data_COM      <= data_q[head_p1];
                        LS_fwd_reg_COM       <= dest_q[head_p1];
                        LS_fwd_data_COM_flag <= 1'b1;
                    end
                end else begin
                    if (wb_q[head_p1] && (dest_q[head_p1] != '0)) begin
                        fwd_data_2_COM      <= data_q[head_p1];
                        fwd_reg_2_COM       <= dest_q[head_p1];
                        fwd_data_2_COM_flag <= 1'b1;
                    end
                    if (kind_q[head_p1] == K_STORE) begin
                        store_commit     <= 1'b1;
                        store_commit_tag <= head_p1;
                    end
                end
            end

            if (alloc1) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                wb_q[tail_q]    <= alloc_wb1;
                kind_q[tail_q]  <= kind_e'(alloc_kind1);
                dest_q[tail_q]  <= alloc_dest1;
            end
            if (alloc2) begin
                valid_q[tail_p1] <= 1'b1;
                done_q[tail_p1]  <= 1'b0;
                wb_q[tail_p1]    <= alloc_wb2;
                kind_q[tail_p1]  <= kind_e'(alloc_kind2);
                dest_q[tail_p1]  <= alloc_dest2;
            end

            // Later writes win: cmpLS > cmp2 > cmp1 on a shared tag.
            if (cmp1_valid && valid_q[cmp1_tag]) begin
                done_q[cmp1_tag] <= 1'b1;
                data_q[cmp1_tag] <= cmp1_data;
            end
            if (cmp2_valid && valid_q[cmp2_tag]) begin
                done_q[cmp2_tag] <= 1'b1;
                data_q[cmp2_tag] <= cmp2_data;
            end
            if (cmpLS_valid && valid_q[cmpLS_tag]) begin
                done_q[cmpLS_tag] <= 1'b1;
                data_q[cmpLS_tag] <= cmpLS_data;
            end

            if (ret_a) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (ret_b) begin
                valid_q[head_p1] <= 1'b0;
                done_q[head_p1]  <= 1'b0;
            end

            // Age is the distance from head; anything past the branch is squashed.
            if (FLUSH) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if ((PTR_W'(i) - head_q) > flush_off) begin
                        valid_q[i] <= 1'b0;
                        done_q[i]  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: vector table of single-entry commits plus
// hand-written dual-retire, memory-op, freeze, fill/wrap, reset and flush sequences.
module tb_rob_commit;

    localparam logic [1:0] K_ALU = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10, K_BR = 2'b11;

    logic        CLK = 1'b0;
    logic        RESET, FREEZE;
    logic        alloc_valid1, alloc_valid2, alloc_wb1, alloc_wb2;
    logic [5:0]  alloc_dest1, alloc_dest2;
    logic [1:0]  alloc_kind1, alloc_kind2;
    logic        alloc_ready;
    logic [5:0]  ROB_tail_pointer1, ROB_tail_pointer2;
    logic        cmp1_valid, cmp2_valid, cmpLS_valid;
    logic [5:0]  cmp1_tag, cmp2_tag, cmpLS_tag;
    logic [31:0] cmp1_data, cmp2_data, cmpLS_data;
    logic        FLUSH;
    logic [5:0]  flush_tag;
    logic [31:0] fwd_data_1_COM, fwd_data_2_COM, LS_fwd_data_COM;
    logic [5:0]  fwd_reg_1_COM, fwd_reg_2_COM, LS_fwd_reg_COM, store_commit_tag;
    logic        fwd_data_1_COM_flag, fwd_data_2_COM_flag, LS_fwd_data_COM_flag, store_commit;
    logic [6:0]  rob_count;

    rob_commit #(.DEPTH(64), .PTR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
        .alloc_valid1(alloc_valid1), .alloc_valid2(alloc_valid2),
        .alloc_dest1(alloc_dest1), .alloc_dest2(alloc_dest2),
        .alloc_wb1(alloc_wb1), .alloc_wb2(alloc_wb2),
        .alloc_kind1(alloc_kind1), .alloc_kind2(alloc_kind2),
        .alloc_ready(alloc_ready),
        .ROB_tail_pointer1(ROB_tail_pointer1), .ROB_tail_pointer2(ROB_tail_pointer2),
        .cmp1_valid(cmp1_valid), .cmp1_tag(cmp1_tag), .cmp1_data(cmp1_data),
        .cmp2_valid(cmp2_valid), .cmp2_tag(cmp2_tag), .cmp2_data(cmp2_data),
        .cmpLS_valid(cmpLS_valid), .cmpLS_tag(cmpLS_tag), .cmpLS_data(cmpLS_data),
        .FLUSH(FLUSH), .flush_tag(flush_tag),
        .fwd_data_1_COM(fwd_data_1_COM), .fwd_data_2_COM(fwd_data_2_COM),
        .fwd_reg_1_COM(fwd_reg_1_COM), .fwd_reg_2_COM(fwd_reg_2_COM),
        .fwd_data_1_COM_flag(fwd_data_1_COM_flag), .fwd_data_2_COM_flag(fwd_data_2_COM_flag),
        .LS_fwd_data_COM(LS_fwd_data_COM), .LS_fwd_reg_COM(LS_fwd_reg_COM),
        .LS_fwd_data_COM_flag(LS_fwd_data_COM_flag),
        .store_commit(store_commit), .store_commit_tag(store_commit_tag),
        .rob_count(rob_count)
    );

    always #5 CLK = ~CLK;

    // slot: 1 = fwd slot 1, 2 = fwd slot 2, 3 = load forward, 4 = store commit (data = tag)
    typedef struct { int slot; logic [5:0] rg; logic [31:0] data; } exp_t;
    typedef struct { logic [1:0] kind; logic [5:0] dest; logic wb; int port; logic [31:0] data; int slot; } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   tb_tail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic take(input int slot, input logic [5:0] r, input logic [31:0] d, input string nm);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: got unexpected commit reg=%0d data=%0h, required no commit", nm, r, d);
        end else begin
            e = sb.pop_front();
            if (e.slot != slot || e.rg !== r || e.data !== d) begin
                fails++;
                $display("FAIL %s: got slot%0d reg=%0d data=%0h, required slot%0d reg=%0d data=%0h",
                         nm, slot, r, d, e.slot, e.rg, e.data);
            end
        end
    endtask

    task automatic monitor();
        if (fwd_data_1_COM_flag === 1'b1) take(1, fwd_reg_1_COM, fwd_data_1_COM, "commit_slot1");
        if (fwd_data_2_COM_flag === 1'b1) take(2, fwd_reg_2_COM, fwd_data_2_COM, "commit_slot2");
        if (LS_fwd_data_COM_flag === 1'b1) take(3, LS_fwd_reg_COM, LS_fwd_data_COM, "commit_load");
        if (store_commit === 1'b1) take(4, 6'd0, {26'd0, store_commit_tag}, "store_commit");
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        monitor();
    endtask

    task automatic push(input int slot, input logic [5:0] r, input logic [31:0] d);
        exp_t e;
        e.slot = slot; e.rg = r; e.data = d;
        sb.push_back(e);
    endtask

    task automatic clear_cmp();
        cmp1_valid = 1'b0; cmp2_valid = 1'b0; cmpLS_valid = 1'b0;
    endtask

    task automatic drive_cmp(input int port, input int tag, input logic [31:0] d);
        case (port)
            1: begin cmp1_valid = 1'b1; cmp1_tag = 6'(tag); cmp1_data = d; end
            2: begin cmp2_valid = 1'b1; cmp2_tag = 6'(tag); cmp2_data = d; end
            default: begin cmpLS_valid = 1'b1; cmpLS_tag = 6'(tag); cmpLS_data = d; end
        endcase
    endtask

    task automatic do_alloc(input logic v2, input logic [1:0] k1, input logic [5:0] d1, input logic w1,
                            input logic [1:0] k2, input logic [5:0] d2, input logic w2);
        alloc_valid1 = 1'b1; alloc_valid2 = v2;
        alloc_kind1 = k1; alloc_dest1 = d1; alloc_wb1 = w1;
        alloc_kind2 = k2; alloc_dest2 = d2; alloc_wb2 = w2;
        #1;
        chk("tail_ptr1", {26'd0, ROB_tail_pointer1}, tb_tail);
        chk("tail_ptr2", {26'd0, ROB_tail_pointer2}, (tb_tail + 1) % 64);
        step();
        alloc_valid1 = 1'b0; alloc_valid2 = 1'b0;
        tb_tail = (tb_tail + (v2 ? 2 : 1)) % 64;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        int   t, h;

        vecs[0] = '{K_ALU,   6'd5, 1'b1, 1, 32'h0000_1234, 1};
        vecs[1] = '{K_BR,    6'd7, 1'b0, 2, 32'hAAAA_0001, 0};
        vecs[2] = '{K_ALU,   6'd0, 1'b1, 1, 32'hBBBB_0002, 0};
        vecs[3] = '{K_LOAD,  6'd9, 1'b1, 3, 32'hCCCC_0003, 3};
        vecs[4] = '{K_STORE, 6'd0, 1'b0, 3, 32'hDDDD_0004, 4};
        vecs[5] = '{K_BR,    6'd3, 1'b1, 2, 32'hEEEE_0005, 1};
        vecs[6] = '{K_LOAD,  6'd0, 1'b1, 3, 32'hFFFF_0006, 0};

        RESET = 1'b0; FREEZE = 1'b0; FLUSH = 1'b0; flush_tag = '0;
        alloc_valid1 = 1'b0; alloc_valid2 = 1'b0; alloc_wb1 = 1'b0; alloc_wb2 = 1'b0;
        alloc_dest1 = '0; alloc_dest2 = '0; alloc_kind1 = '0; alloc_kind2 = '0;
        cmp1_tag = '0; cmp2_tag = '0; cmpLS_tag = '0;
        cmp1_data = '0; cmp2_data = '0; cmpLS_data = '0;
        clear_cmp();

        step(); step();
        RESET = 1'b1;
        #1;
        chk("reset_count", {25'd0, rob_count}, 0);
        chk("reset_ready", {31'd0, alloc_ready}, 1);
        chk("reset_ptr1", {26'd0, ROB_tail_pointer1}, 0);
        chk("reset_ptr2", {26'd0, ROB_tail_pointer2}, 1);
        chk("reset_fwd1", fwd_data_1_COM, 0);
        chk("reset_flags", {28'd0, fwd_data_1_COM_flag, fwd_data_2_COM_flag, LS_fwd_data_COM_flag, store_commit}, 0);

        // Single-entry vectors: alloc, complete, retire exactly one edge later.
        for (int i = 0; i < 7; i++) begin
            t = tb_tail;
            do_alloc(1'b0, vecs[i].kind, vecs[i].dest, vecs[i].wb, K_ALU, 6'd0, 1'b0);
            drive_cmp(vecs[i].port, t, vecs[i].data);
            if (vecs[i].slot == 4) push(4, 6'd0, 32'(t));
            else if (vecs[i].slot != 0) push(vecs[i].slot, vecs[i].dest, vecs[i].data);
            step();
            clear_cmp();
            chk("vec_pending", sb.size(), (vecs[i].slot != 0) ? 1 : 0);
            chk("vec_count_done", {25'd0, rob_count}, 1);
            step();
            chk("vec_drained", sb.size(), 0);
            chk("vec_count_empty", {25'd0, rob_count}, 0);
        end

        // Same-tag completions: LS beats 2 beats 1.
        t = tb_tail;
        do_alloc(1'b1, K_ALU, 6'd30, 1'b1, K_ALU, 6'd31, 1'b1);
        drive_cmp(1, t, 32'h1111_0001); drive_cmp(2, t, 32'h2222_0001); drive_cmp(3, t, 32'h3333_0001);
        push(1, 6'd30, 32'h3333_0001);
        step();
        clear_cmp();
        drive_cmp(1, (t + 1) % 64, 32'h1111_0002); drive_cmp(2, (t + 1) % 64, 32'h2222_0002);
        push(1, 6'd31, 32'h2222_0002);
        step();
        clear_cmp();
        chk("prio_pending", sb.size(), 1);
        step();
        chk("prio_drained", sb.size(), 0);

        // Out-of-order completion, dual in-order retire.
        t = tb_tail;
        do_alloc(1'b1, K_ALU, 6'd10, 1'b1, K_ALU, 6'd11, 1'b1);
        drive_cmp(1, (t + 1) % 64, 32'h0000_B0B1);
        step();
        clear_cmp();
        chk("dual_young_only", {25'd0, rob_count}, 2);
        drive_cmp(2, t, 32'h0000_A0A0);
        push(1, 6'd10, 32'h0000_A0A0);
        push(2, 6'd11, 32'h0000_B0B1);
        step();
        clear_cmp();
        chk("dual_pending", sb.size(), 2);
        step();
        chk("dual_drained", sb.size(), 0);
        chk("dual_count", {25'd0, rob_count}, 0);

        // Load then store: one memory op per edge.
        t = tb_tail;
        do_alloc(1'b1, K_LOAD, 6'd12, 1'b1, K_STORE, 6'd0, 1'b0);
        drive_cmp(3, t, 32'h5A5A_0012);
        drive_cmp(2, (t + 1) % 64, 32'h0);
        push(3, 6'd12, 32'h5A5A_0012);
        push(4, 6'd0, 32'((t + 1) % 64));
        step();
        clear_cmp();
        chk("ls_pending", sb.size(), 2);
        step();
        chk("ls_load_first", sb.size(), 1);
        step();
        chk("ls_store_second", sb.size(), 0);
        chk("ls_count", {25'd0, rob_count}, 0);

        // FREEZE holds retirement and allocation.
        t = tb_tail;
        do_alloc(1'b0, K_ALU, 6'd13, 1'b1, K_ALU, 6'd0, 1'b0);
        drive_cmp(1, t, 32'hF00D_0013);
        push(1, 6'd13, 32'hF00D_0013);
        step();
        clear_cmp();
        FREEZE = 1'b1; alloc_valid1 = 1'b1;
        step();
        alloc_valid1 = 1'b0;
        chk("freeze_no_retire", sb.size(), 1);
        chk("freeze_no_alloc", {26'd0, ROB_tail_pointer1}, tb_tail);
        chk("freeze_count", {25'd0, rob_count}, 1);
        FREEZE = 1'b0;
        step();
        chk("freeze_release", sb.size(), 0);

        // Fill to 64 entries, wrapping the tail.
        h = tb_tail;
        for (int i = 0; i < 32; i++) do_alloc(1'b1, K_ALU, 6'd1, 1'b0, K_ALU, 6'd2, 1'b0);
        #1;
        chk("full_count", {25'd0, rob_count}, 64);
        chk("full_ready", {31'd0, alloc_ready}, 0);
        alloc_valid1 = 1'b1;
        step();
        alloc_valid1 = 1'b0;
        chk("full_no_alloc_ptr", {26'd0, ROB_tail_pointer1}, h);
        chk("full_no_alloc_count", {25'd0, rob_count}, 64);
        drive_cmp(1, h, 32'h0); drive_cmp(2, (h + 1) % 64, 32'h0);
        step();
        clear_cmp();
        step();
        chk("full_retire2_count", {25'd0, rob_count}, 62);
        chk("full_retire2_ready", {31'd0, alloc_ready}, 1);

        // Reset mid-stream with done entries waiting behind the head.
        drive_cmp(1, (h + 4) % 64, 32'h1); drive_cmp(2, (h + 5) % 64, 32'h2);
        step();
        clear_cmp();
        RESET = 1'b0; alloc_valid1 = 1'b1; FLUSH = 1'b1; flush_tag = 6'd20;
        drive_cmp(3, (h + 2) % 64, 32'h3);
        step();
        RESET = 1'b1; alloc_valid1 = 1'b0; FLUSH = 1'b0;
        clear_cmp();
        #1;
        tb_tail = 0;
        chk("rst_mid_count", {25'd0, rob_count}, 0);
        chk("rst_mid_ptr1", {26'd0, ROB_tail_pointer1}, 0);
        chk("rst_mid_ready", {31'd0, alloc_ready}, 1);
        chk("rst_mid_fwd1", fwd_data_1_COM, 0);
        chk("rst_mid_fwd2", fwd_data_2_COM, 0);
        chk("rst_mid_reg1", {26'd0, fwd_reg_1_COM}, 0);
        chk("rst_mid_ls", LS_fwd_data_COM, 0);
        chk("rst_mid_ls_reg", {26'd0, LS_fwd_reg_COM}, 0);
        chk("rst_mid_store_tag", {26'd0, store_commit_tag}, 0);
        drive_cmp(1, 0, 32'hDEAD_0000);
        step();
        clear_cmp();
        step(); step(); step();
        chk("rst_mid_quiet", {25'd0, rob_count}, 0);

        // Flush: tags 0..9 allocated, branch at 5, 0/1 retire on the flush edge.
        for (int i = 0; i < 5; i++) do_alloc(1'b1, K_ALU, 6'd1, 1'b0, K_ALU, 6'd1, 1'b0);
        drive_cmp(1, 0, 32'h0); drive_cmp(2, 1, 32'h0);
        step();
        clear_cmp();
        FLUSH = 1'b1; flush_tag = 6'd5; alloc_valid1 = 1'b1;
        #1;
        chk("flush_ready_low", {31'd0, alloc_ready}, 0);
        step();
        FLUSH = 1'b0; alloc_valid1 = 1'b0;
        tb_tail = 6;
        chk("flush_tail", {26'd0, ROB_tail_pointer1}, 6);
        chk("flush_count", {25'd0, rob_count}, 4);
        drive_cmp(1, 7, 32'h7777_7777); drive_cmp(2, 2, 32'h0); drive_cmp(3, 3, 32'h0);
        step();
        clear_cmp();
        chk("flush_cmp_squashed", {25'd0, rob_count}, 4);
        drive_cmp(1, 4, 32'h0); drive_cmp(2, 5, 32'h0);
        step();
        clear_cmp();
        chk("flush_drain", {25'd0, rob_count}, 2);
        FLUSH = 1'b1; flush_tag = 6'd5;
        step();
        FLUSH = 1'b0;
        chk("flush_self_retired_count", {25'd0, rob_count}, 0);
        chk("flush_self_retired_tail", {26'd0, ROB_tail_pointer1}, 6);
        do_alloc(1'b1, K_ALU, 6'd20, 1'b1, K_ALU, 6'd21, 1'b1);
        drive_cmp(1, 6, 32'h0000_0606);
        push(1, 6'd20, 32'h0000_0606);
        step();
        clear_cmp();
        step();
        chk("realloc_head_retired", sb.size(), 0);
        chk("realloc_young_waits", {25'd0, rob_count}, 1);
        drive_cmp(2, 7, 32'h0000_0707);
        push(1, 6'd21, 32'h0000_0707);
        step();
        clear_cmp();
        step();
        chk("realloc_drained", {25'd0, rob_count}, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL take parameters: DEPTH, 64, number of ROB entries; PTR_W, 6, tag/pointer width; DATA_W, 32, result width.
REQ-002 SHALL have ports (name direction width meaning):
- CLK in 1 clock
- RESET in 1 synchronous active-low reset
- FREEZE in 1 suppresses allocation and commit
- alloc_valid1/alloc_valid2 in 1 dispatch requests; slot 2 valid only with slot 1
- alloc_dest1/alloc_dest2 in 6 destination register
- alloc_wb1/alloc_wb2 in 1 entry writes back
- alloc_kind1/alloc_kind2 in 2 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
- alloc_ready out 1 two free entries and no FLUSH
- ROB_tail_pointer1/ROB_tail_pointer2 out 6 tags granted to slots 1/2
- cmp1_valid/cmp2_valid/cmpLS_valid in 1 completions: ALU, branch, load/store ports
- cmp1_tag/cmp2_tag/cmpLS_tag in 6 completing entry tag
- cmp1_data/cmp2_data/cmpLS_data in 32 result
- FLUSH in 1 mispredict flush
- flush_tag in 6 mispredicted branch tag
- fwd_data_1_COM/fwd_data_2_COM out 32 commit-slot results
- fwd_reg_1_COM/fwd_reg_2_COM out 6 commit-slot registers
- fwd_data_1_COM_flag/fwd_data_2_COM_flag out 1 commit-slot valid
- LS_fwd_data_COM out 32; LS_fwd_reg_COM out 6; LS_fwd_data_COM_flag out 1: committed load
- store_commit out 1; store_commit_tag out 6: store retired
- rob_count out 7 occupied entries

Function
REQ-003 SHALL be a circular buffer, head/tail PTR_W bits, wrapping 63->0; entry: valid, done, wb, kind, dest, data.
REQ-004 SHALL drive ROB_tail_pointer1 = tail, ROB_tail_pointer2 = tail+1 mod 64, combinationally.
REQ-005 SHALL assert alloc_ready when (64 - rob_count) >= 2 and FLUSH low.
REQ-006 SHALL, on a clock edge with alloc_ready, FREEZE low, alloc_valid1: write entry at tail (valid=1, done=0); if also alloc_valid2, write tail+1; advance tail by 1 or 2. alloc_valid2 without alloc_valid1 ignored.
REQ-007 SHALL, on each cmp*_valid whose tag hits a valid entry, set done=1 and store data at the edge; completions to invalid entries ignored; accepted during FREEZE.
REQ-008 SHALL, same-tag simultaneous completions: priority cmpLS > cmp2 > cmp1.
REQ-009 SHALL retire in order, up to 2 per edge: slot A = head if valid and done; slot B = head+1 if A retires, valid, done.
REQ-010 SHALL block slot B when A and B are both LOAD/STORE (max one memory op per edge).
REQ-011 SHALL register commit outputs at the retire edge: non-load with wb=1 and dest!=0 -> fwd_*_1_COM (slot A) / fwd_*_2_COM (slot B), flag=1; load with wb=1, dest!=0 -> LS_fwd_*_COM, flag=1; store -> store_commit=1, store_commit_tag.
REQ-012 SHALL deassert all flags and store_commit in cycles without matching retire, incl. FREEZE; data/reg outputs hold.
REQ-013 SHALL, on FLUSH at an edge, invalidate entries strictly younger than flush_tag, set tail = flush_tag+1, drop that edge's allocation; retirements up to flush_tag proceed.
REQ-014 SHALL recompute rob_count after flush as ((flush_tag - head_next) mod 64)+1, or 0 if flush_tag retired that edge.
REQ-015 SHALL update rob_count = count + allocated - retired per edge, range 0..64; rob_count=64 is full, 0 empty.
REQ-016 SHALL give completion-to-flag latency of one edge: done set at edge k, flag visible after edge k+1 when entry is head.

Reset
REQ-017 SHALL, RESET low at a rising edge, clear head, tail, rob_count, all valid/done bits, all outputs to 0, overriding allocation, completion, flush.
REQ-018 SHALL, reset mid-operation, drop all in-flight entries; no commit flag after reset release until a new entry completes.

Verification
REQ-019 Alloc ALU r5 tag0, complete tag0 data 0x1234 -> next edge fwd_reg_1_COM=5, fwd_data_1_COM=0x1234, flag=1 one cycle.
REQ-020 Alloc tags 0,1; complete tag1 then tag0 -> both retire same edge, slot1=tag0, slot2=tag1.
REQ-021 Alloc LOAD tag0, STORE tag1, both done -> edge1 LS flag only; edge2 store_commit=1, tag=1.
REQ-022 Fill 64 entries -> alloc_ready=0, rob_count=64; retire 2 -> alloc_ready=1; tail wraps 63->0.
REQ-023 Alloc tags 3..9, FLUSH flush_tag=5 -> tail=6, tags 6..9 invalid, later cmp to tag 7 ignored.
REQ-024 RESET low mid-stream with done entries -> all outputs 0, rob_count=0, no flags after release.
